// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_pkg                                                                    |
// | ALU opcode codes, RV64 decode fields and issue FSM states for alu_issue.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package alu_pkg;

  localparam int ALU_OP_W = 11;

  localparam logic [ALU_OP_W-1:0] c_ALU_NOTHING   = 11'd0;
  localparam logic [ALU_OP_W-1:0] c_ALU_ADD       = 11'd1;
  localparam logic [ALU_OP_W-1:0] c_ALU_SUB       = 11'd2;
  localparam logic [ALU_OP_W-1:0] c_ALU_AND       = 11'd3;
  localparam logic [ALU_OP_W-1:0] c_ALU_OR        = 11'd4;
  localparam logic [ALU_OP_W-1:0] c_ALU_XOR       = 11'd5;
  localparam logic [ALU_OP_W-1:0] c_ALU_SLL       = 11'd6;
  localparam logic [ALU_OP_W-1:0] c_ALU_SRL       = 11'd7;
  localparam logic [ALU_OP_W-1:0] c_ALU_MUL       = 11'd8;
  localparam logic [ALU_OP_W-1:0] c_ALU_DIV       = 11'd9;
  localparam logic [ALU_OP_W-1:0] c_ALU_REM       = 11'd10;
  localparam logic [ALU_OP_W-1:0] c_ALU_SLT       = 11'd11;
  localparam logic [ALU_OP_W-1:0] c_ALU_ARTHRIGHT = 11'd12;

  localparam logic [6:0] c_RV_OP     = 7'b0110011;
  localparam logic [6:0] c_RV_OP_IMM = 7'b0010011;

  localparam logic [2:0] c_F3_ADD_SUB = 3'b000;
  localparam logic [2:0] c_F3_SLL     = 3'b001;
  localparam logic [2:0] c_F3_XOR     = 3'b100;
  localparam logic [2:0] c_F3_SRL     = 3'b101;
  localparam logic [2:0] c_F3_OR      = 3'b110;
  localparam logic [2:0] c_F3_AND     = 3'b111;
  localparam logic [2:0] c_F3_MUL     = 3'b000;
  localparam logic [2:0] c_F3_DIV     = 3'b100;
  localparam logic [2:0] c_F3_REM     = 3'b110;

  localparam logic [6:0] c_F7_BASE = 7'b0000000;
  localparam logic [6:0] c_F7_ALT  = 7'b0100000;
  localparam logic [6:0] c_F7_MEXT = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  function automatic logic [63:0] sext12(input logic [11:0] imm);
    return {{52{imm[11]}}, imm};
  endfunction

endpackage
`default_nettype wire

// File: rtl/issue_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | issue_regfile                                                              |
// | 32x64 register file, two async read ports, one write port, x0 hardwired.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module issue_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic [63:0] o_rs1_data,
  output logic [63:0] o_rs2_data,
  input  logic        i_we,
  input  logic [4:0]  i_wr_addr,
  input  logic [63:0] i_wr_data
);

  logic [63:0] r_regs [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_we && (i_wr_addr != 5'd0)) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rs1_data = (i_rs1_addr == 5'd0) ? 64'd0 : r_regs[i_rs1_addr];
  assign o_rs2_data = (i_rs2_addr == 5'd0) ? 64'd0 : r_regs[i_rs2_addr];

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_issue                                                                  |
// | Single-issue RV64 integer decode/issue stage driving an external ALU.      |
// | Option macro: ALU_ISSUE_MEXT_EN (adds MUL/DIV/REM decode).                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_issue
  import alu_pkg::*;
#(
  parameter int EXEC_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  output logic [10:0]        alu_opcode,
  output logic signed [63:0] alu_value1,
  output logic signed [63:0] alu_value2,
  output logic signed [31:0] alu_immediate,
  output logic [5:0]         alu_shamt,
  input  logic [63:0]        alu_result,
  output logic               retire_valid,
  output logic [4:0]         retire_rd,
  output logic [63:0]        retire_data,
  output logic               illegal
);

  localparam logic [3:0] c_COUNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_count;
  logic [10:0] r_op;
  logic [63:0] r_v1, r_v2, r_data, r_bypass_data;
  logic [31:0] r_imm;
  logic [5:0]  r_shamt;
  logic [4:0]  r_rd;
  logic        r_bypass, r_illegal;

  logic [63:0] w_rs1_data, w_rs2_data, w_imm64, w_v1, w_v2, w_bypass_data;
  logic [10:0] w_op;
  logic [31:0] w_imm;
  logic [5:0]  w_shamt;
  logic        w_legal, w_bypass, w_accept;
  logic [11:0] w_imm12;

  assign w_imm12  = in_instr[31:20];
  assign w_imm64  = sext12(w_imm12);
  assign w_accept = in_valid && in_ready;

  issue_regfile u_regfile (
    .clk        (clk),
    .rst        (reset),
    .i_rs1_addr (in_instr[19:15]),
    .i_rs2_addr (in_instr[24:20]),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data),
    .i_we       (r_state == S_WB),
    .i_wr_addr  (r_rd),
    .i_wr_data  (r_data)
  );

  always_comb begin
    w_legal       = 1'b0;
    w_bypass      = 1'b0;
    w_bypass_data = '0;
    w_op          = c_ALU_NOTHING;
    w_v1          = w_rs1_data;
    w_v2          = '0;
    w_imm         = '0;
    w_shamt       = '0;
    if (in_instr[6:0] == c_RV_OP) begin
      w_v2 = w_rs2_data;
      case (in_instr[31:25])
        c_F7_BASE: begin
          case (in_instr[14:12])
            c_F3_ADD_SUB: begin w_legal = 1'b1; w_op = c_ALU_ADD; end
            c_F3_XOR:     begin w_legal = 1'b1; w_op = c_ALU_XOR; end
            c_F3_OR:      begin w_legal = 1'b1; w_op = c_ALU_OR;  end
            c_F3_AND:     begin w_legal = 1'b1; w_op = c_ALU_AND; end
            c_F3_SLL, c_F3_SRL: begin
              w_legal = 1'b1;
              w_op    = (in_instr[14:12] == c_F3_SLL) ? c_ALU_SLL : c_ALU_SRL;
              w_v2    = '0;
              w_shamt = w_rs2_data[5:0];
            end
            default: ;
          endcase
        end
        c_F7_ALT: begin
          if (in_instr[14:12] == c_F3_ADD_SUB) begin
            w_legal = 1'b1;
            w_op    = c_ALU_SUB;
          end
        end
`ifdef ALU_ISSUE_MEXT_EN
        c_F7_MEXT: begin
          case (in_instr[14:12])
            c_F3_MUL: begin w_legal = 1'b1; w_op = c_ALU_MUL; end
            c_F3_DIV, c_F3_REM: begin
              w_legal = 1'b1;
              w_op    = (in_instr[14:12] == c_F3_DIV) ? c_ALU_DIV : c_ALU_REM;
              // Divide by zero never reaches the ALU; the RISC-V result is fixed.
              if (w_rs2_data == 64'd0) begin
                w_bypass      = 1'b1;
                w_bypass_data = (in_instr[14:12] == c_F3_DIV) ? '1 : w_rs1_data;
                w_op          = c_ALU_NOTHING;
                w_v1          = '0;
                w_v2          = '0;
              end
            end
            default: ;
          endcase
        end
`endif
        default: ;
      endcase
    end else if (in_instr[6:0] == c_RV_OP_IMM) begin
      w_v2  = w_imm64;
      w_imm = w_imm64[31:0];
      case (in_instr[14:12])
        c_F3_ADD_SUB: begin w_legal = 1'b1; w_op = c_ALU_ADD; end
        c_F3_XOR:     begin w_legal = 1'b1; w_op = c_ALU_XOR; end
        c_F3_OR:      begin w_legal = 1'b1; w_op = c_ALU_OR;  end
        c_F3_AND:     begin w_legal = 1'b1; w_op = c_ALU_AND; end
        c_F3_SLL, c_F3_SRL: begin
          w_legal = (w_imm12[11:6] == 6'd0);
          w_op    = (in_instr[14:12] == c_F3_SLL) ? c_ALU_SLL : c_ALU_SRL;
          w_v2    = '0;
          w_imm   = '0;
          w_shamt = w_imm12[5:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    in_ready      = 1'b0;
    alu_opcode    = c_ALU_NOTHING;
    alu_value1    = '0;
    alu_value2    = '0;
    alu_immediate = '0;
    alu_shamt     = '0;
    retire_valid  = 1'b0;
    retire_rd     = '0;
    retire_data   = '0;
    illegal       = 1'b0;
    case (r_state)
      S_IDLE:  if (w_accept && w_legal) w_state_nxt = S_EXEC;
      S_EXEC:  if (r_count == 4'd0) w_state_nxt = S_WB;
      S_WB:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (!reset) begin
      in_ready = (r_state == S_IDLE);
      illegal  = r_illegal;
      if (r_state == S_EXEC) begin
        alu_opcode    = r_op;
        alu_value1    = r_v1;
        alu_value2    = r_v2;
        alu_immediate = r_imm;
        alu_shamt     = r_shamt;
      end
      if (r_state == S_WB) begin
        retire_valid = 1'b1;
        retire_rd    = r_rd;
        retire_data  = r_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count       <= '0;
      r_op          <= c_ALU_NOTHING;
      r_v1          <= '0;
      r_v2          <= '0;
      r_imm         <= '0;
      r_shamt       <= '0;
      r_rd          <= '0;
      r_data        <= '0;
      r_bypass      <= 1'b0;
      r_bypass_data <= '0;
      r_illegal     <= 1'b0;
    end else begin
      r_illegal <= w_accept && !w_legal;
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_legal) begin
            r_count       <= c_COUNT_LOAD;
            r_op          <= w_op;
            r_v1          <= w_v1;
            r_v2          <= w_v2;
            r_imm         <= w_imm;
            r_shamt       <= w_shamt;
            r_rd          <= in_instr[11:7];
            r_bypass      <= w_bypass;
            r_bypass_data <= w_bypass_data;
          end
        end
        S_EXEC: begin
          if (r_count == 4'd0) r_data <= r_bypass ? r_bypass_data : alu_result;
          else                 r_count <= r_count - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_issue                                                               |
// | Table plus random bench for alu_issue with a behavioural ALU and RV model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_alu_issue;
  import alu_pkg::*;

  localparam int EC = 3;
`ifdef ALU_ISSUE_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic [31:0]        in_instr = '0;
  logic               in_ready;
  logic [10:0]        alu_opcode;
  logic signed [63:0] alu_value1, alu_value2;
  logic signed [31:0] alu_immediate;
  logic [5:0]         alu_shamt;
  logic [63:0]        alu_result;
  logic               retire_valid;
  logic [4:0]         retire_rd;
  logic [63:0]        retire_data;
  logic               illegal;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] model_rf [32];

  always #5 clk = ~clk;

  alu_issue #(.EXEC_CYCLES(EC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .alu_opcode(alu_opcode), .alu_value1(alu_value1),
    .alu_value2(alu_value2), .alu_immediate(alu_immediate), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .retire_valid(retire_valid), .retire_rd(retire_rd),
    .retire_data(retire_data), .illegal(illegal)
  );

  // External ALU stand-in; unknown opcodes return a marker so a missing bypass is visible.
  always_comb begin
    case (alu_opcode)
      c_ALU_ADD: alu_result = alu_value1 + alu_value2;
      c_ALU_SUB: alu_result = alu_value1 - alu_value2;
      c_ALU_AND: alu_result = alu_value1 & alu_value2;
      c_ALU_OR:  alu_result = alu_value1 | alu_value2;
      c_ALU_XOR: alu_result = alu_value1 ^ alu_value2;
      c_ALU_SLL: alu_result = alu_value1 << alu_shamt;
      c_ALU_SRL: alu_result = $unsigned(alu_value1) >> alu_shamt;
      c_ALU_MUL: alu_result = alu_value1 * alu_value2;
      c_ALU_DIV: alu_result = (alu_value2 == 0) ? 64'hDEAD_DEAD_DEAD_DEAD : alu_value1 / alu_value2;
      c_ALU_REM: alu_result = (alu_value2 == 0) ? 64'hDEAD_DEAD_DEAD_DEAD : alu_value1 % alu_value2;
      default:   alu_result = 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
  end

  typedef struct packed {
    logic        legal;
    logic [10:0] op;
    logic [63:0] v1;
    logic [63:0] v2;
    logic [31:0] imm;
    logic [5:0]  shamt;
    logic [63:0] res;
    logic [4:0]  rd;
  } exp_t;

  typedef struct packed {
    logic [31:0] ins;
    logic        ill;
    logic [4:0]  rd;
    logic [63:0] data;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  // Instruction-level reference: what the ALU should see and what should retire.
  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    logic [63:0] a, b, simm;
    a    = model_rf[ins[19:15]];
    b    = model_rf[ins[24:20]];
    simm = {{52{ins[31]}}, ins[31:20]};
    e    = '0;
    e.rd = ins[11:7];
    if (ins[6:0] == 7'h33) begin
      e.legal = 1'b1; e.v1 = a; e.v2 = b;
      case ({ins[31:25], ins[14:12]})
        {7'h00, 3'd0}: begin e.op = c_ALU_ADD; e.res = a + b; end
        {7'h20, 3'd0}: begin e.op = c_ALU_SUB; e.res = a - b; end
        {7'h00, 3'd4}: begin e.op = c_ALU_XOR; e.res = a ^ b; end
        {7'h00, 3'd6}: begin e.op = c_ALU_OR;  e.res = a | b; end
        {7'h00, 3'd7}: begin e.op = c_ALU_AND; e.res = a & b; end
        {7'h00, 3'd1}: begin e.op = c_ALU_SLL; e.v2 = 0; e.shamt = b[5:0]; e.res = a << b[5:0]; end
        {7'h00, 3'd5}: begin e.op = c_ALU_SRL; e.v2 = 0; e.shamt = b[5:0]; e.res = a >> b[5:0]; end
        {7'h01, 3'd0}: begin e.legal = MEXT; e.op = c_ALU_MUL; e.res = a * b; end
        {7'h01, 3'd4}: begin
          e.legal = MEXT;
          if (b == 0) begin e.op = c_ALU_NOTHING; e.v1 = 0; e.v2 = 0; e.res = '1; end
          else begin e.op = c_ALU_DIV; e.res = $signed(a) / $signed(b); end
        end
        {7'h01, 3'd6}: begin
          e.legal = MEXT;
          if (b == 0) begin e.op = c_ALU_NOTHING; e.v1 = 0; e.v2 = 0; e.res = a; end
          else begin e.op = c_ALU_REM; e.res = $signed(a) % $signed(b); end
        end
        default: e.legal = 1'b0;
      endcase
    end else if (ins[6:0] == 7'h13) begin
      e.legal = 1'b1; e.v1 = a; e.v2 = simm; e.imm = simm[31:0];
      case (ins[14:12])
        3'd0: begin e.op = c_ALU_ADD; e.res = a + simm; end
        3'd4: begin e.op = c_ALU_XOR; e.res = a ^ simm; end
        3'd6: begin e.op = c_ALU_OR;  e.res = a | simm; end
        3'd7: begin e.op = c_ALU_AND; e.res = a & simm; end
        3'd1, 3'd5: begin
          e.legal = (ins[31:26] == 6'd0);
          e.op    = (ins[14:12] == 3'd1) ? c_ALU_SLL : c_ALU_SRL;
          e.v2 = 0; e.imm = 0; e.shamt = ins[25:20];
          e.res = (ins[14:12] == 3'd1) ? (a << ins[25:20]) : (a >> ins[25:20]);
        end
        default: e.legal = 1'b0;
      endcase
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge of the first cycle the block is idle again.
  task automatic run_instr(input logic [31:0] ins, input logic use_tab, input logic t_ill,
                           input logic [4:0] t_rd, input logic [63:0] t_data);
    exp_t e;
    logic exp_ill;
    logic [4:0] exp_rd;
    logic [63:0] exp_data;
    int w;
    e        = model(ins);
    exp_ill  = use_tab ? t_ill  : !e.legal;
    exp_rd   = use_tab ? t_rd   : e.rd;
    exp_data = use_tab ? t_data : e.res;
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    chk("in_ready_idle", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    in_instr = ins;
    @(negedge clk);
    in_valid = 1'b0;
    in_instr = $urandom();
    if (exp_ill) begin
      chk("illegal_pulse", 64'(illegal), 64'(1));
      chk("illegal_no_retire", 64'(retire_valid), 64'(0));
      chk("illegal_stays_idle", 64'(in_ready), 64'(1));
      @(negedge clk);
      chk("illegal_one_cycle", 64'(illegal), 64'(0));
      chk("illegal_no_late_retire", 64'(retire_valid), 64'(0));
    end else begin
      chk("legal_no_illegal", 64'(illegal), 64'(0));
      for (int k = 0; k < EC; k++) begin
        if (k > 0) @(negedge clk);
        chk("exec_opcode", 64'(alu_opcode), 64'(e.op));
        chk("exec_value1", 64'(alu_value1), e.v1);
        chk("exec_value2", 64'(alu_value2), e.v2);
        chk("exec_immediate", 64'($unsigned(alu_immediate)), 64'(e.imm));
        chk("exec_shamt", 64'(alu_shamt), 64'(e.shamt));
        chk("exec_no_retire", 64'(retire_valid), 64'(0));
        chk("exec_not_ready", 64'(in_ready), 64'(0));
      end
      @(negedge clk);
      chk("wb_retire_valid", 64'(retire_valid), 64'(1));
      chk("wb_retire_rd", 64'(retire_rd), 64'(exp_rd));
      chk("wb_retire_data", retire_data, exp_data);
      chk("wb_opcode_nothing", 64'(alu_opcode), 64'(c_ALU_NOTHING));
      if (exp_rd != 5'd0) model_rf[exp_rd] = exp_data;
      @(negedge clk);
      chk("post_wb_retire_low", 64'(retire_valid), 64'(0));
      chk("post_wb_data_zero", retire_data, 64'(0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[$];
    logic [31:0] ins;
    logic [4:0] rd, rs1, rs2;
    logic [11:0] imm;
    int sel;

    for (int i = 0; i < 32; i++) model_rf[i] = '0;

    tab.push_back('{enc_i(12'd5, 5'd0, 3'd0, 5'd1),       1'b0, 5'd1,  64'd5});
    tab.push_back('{enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2),  1'b0, 5'd2,  64'd10});
    tab.push_back('{enc_i(12'd7, 5'd0, 3'd0, 5'd3),       1'b0, 5'd3,  64'd7});
    tab.push_back('{enc_i(12'd0, 5'd0, 3'd0, 5'd3),       1'b0, 5'd3,  64'd0});
    tab.push_back('{enc_i(12'd1, 5'd0, 3'd0, 5'd6),       1'b0, 5'd6,  64'd1});
    tab.push_back('{enc_i(12'd63, 5'd6, 3'd1, 5'd4),      1'b0, 5'd4,  64'h8000_0000_0000_0000});
    tab.push_back('{enc_i(12'h401, 5'd4, 3'd5, 5'd7),     1'b1, 5'd0,  64'd0});
    tab.push_back('{enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd0),  1'b0, 5'd0,  64'd10});
    tab.push_back('{enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd8),  1'b0, 5'd8,  64'd0});
    tab.push_back('{enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd9),  1'b0, 5'd9,  64'hFFFF_FFFF_FFFF_FFFB});
    tab.push_back('{enc_i(12'hFFF, 5'd1, 3'd4, 5'd10),    1'b0, 5'd10, 64'hFFFF_FFFF_FFFF_FFFA});
    tab.push_back('{enc_r(7'h00, 5'd1, 5'd4, 3'd5, 5'd11), 1'b0, 5'd11, 64'h0400_0000_0000_0000});
    tab.push_back('{enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd12), 1'b1, 5'd0,  64'd0});
    tab.push_back('{enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd12), !MEXT, 5'd12, 64'd50});
    tab.push_back('{enc_i(12'd9, 5'd0, 3'd0, 5'd13),      1'b0, 5'd13, 64'd9});
    tab.push_back('{enc_r(7'h01, 5'd0, 5'd13, 3'd4, 5'd5), !MEXT, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF});
    tab.push_back('{enc_r(7'h01, 5'd0, 5'd13, 3'd6, 5'd5), !MEXT, 5'd5, 64'd9});
    tab.push_back('{enc_r(7'h01, 5'd1, 5'd2, 3'd4, 5'd14), !MEXT, 5'd14, 64'd2});
    tab.push_back('{enc_i(12'h0F0, 5'd9, 3'd7, 5'd15),    1'b0, 5'd15, 64'h0F0});
    tab.push_back('{enc_i(12'h0A0, 5'd1, 3'd6, 5'd15),    1'b0, 5'd15, 64'h0A5});
    tab.push_back('{enc_i(12'd63, 5'd4, 3'd5, 5'd16),     1'b0, 5'd16, 64'd1});

    repeat (3) @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'(0));
    chk("reset_retire_valid", 64'(retire_valid), 64'(0));
    chk("reset_illegal", 64'(illegal), 64'(0));
    chk("reset_opcode", 64'(alu_opcode), 64'(c_ALU_NOTHING));
    reset = 1'b0;
    #1;
    chk("after_reset_in_ready", 64'(in_ready), 64'(1));

    foreach (tab[i]) run_instr(tab[i].ins, 1'b1, tab[i].ill, tab[i].rd, tab[i].data);

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 14);
      rd  = 5'($urandom_range(0, 15));
      rs1 = 5'($urandom_range(0, 15));
      rs2 = 5'($urandom_range(0, 15));
      imm = 12'($urandom());
      case (sel)
        0:  ins = enc_r(7'h00, rs2, rs1, 3'd0, rd);
        1:  ins = enc_r(7'h20, rs2, rs1, 3'd0, rd);
        2:  ins = enc_r(7'h00, rs2, rs1, 3'd4, rd);
        3:  ins = enc_r(7'h00, rs2, rs1, 3'd6, rd);
        4:  ins = enc_r(7'h00, rs2, rs1, 3'd7, rd);
        5:  ins = enc_r(7'h00, rs2, rs1, 3'd1, rd);
        6:  ins = enc_r(7'h00, rs2, rs1, 3'd5, rd);
        7:  ins = enc_i(imm, rs1, 3'd0, rd);
        8:  ins = enc_i(imm, rs1, 3'd4, rd);
        9:  ins = enc_i(imm, rs1, 3'd6, rd);
        10: ins = enc_i(imm, rs1, 3'd7, rd);
        11: ins = enc_i({6'd0, imm[5:0]}, rs1, 3'd1, rd);
        12: ins = enc_i({6'd0, imm[5:0]}, rs1, 3'd5, rd);
        13: ins = enc_r(7'h01, rs2, rs1, 3'd0, rd);
        default: ins = enc_r(7'h20, rs2, rs1, 3'd5, rd);
      endcase
      run_instr(ins, 1'b0, 1'b0, 5'd0, 64'd0);
    end

    // Reset landing in the second EXEC cycle must abort without retire.
    in_valid = 1'b1;
    in_instr = enc_i(12'd123, 5'd0, 3'd0, 5'd15);
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_exec_opcode", 64'(alu_opcode), 64'(c_ALU_ADD));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_reset_ready_low", 64'(in_ready), 64'(0));
    chk("abort_reset_opcode_zero", 64'(alu_opcode), 64'(c_ALU_NOTHING));
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_retire_in_reset", 64'(retire_valid), 64'(0));
      chk("abort_in_ready_in_reset", 64'(in_ready), 64'(0));
    end
    reset = 1'b0;
    #1;
    chk("abort_ready_after_reset", 64'(in_ready), 64'(1));
    for (int i = 0; i < 32; i++) model_rf[i] = '0;
    repeat (5) begin
      @(negedge clk);
      chk("abort_no_retire_after", 64'(retire_valid), 64'(0));
    end
    run_instr(enc_r(7'h00, 5'd0, 5'd15, 3'd0, 5'd8), 1'b1, 1'b0, 5'd8, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter EXEC_CYCLES, default 1, cycles alu_result is held before capture (legal 1..15).
REQ-002 SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  instruction offered.
REQ-005 SHALL have port in_ready  output  1  block accepts instruction this cycle.
REQ-006 SHALL have port in_instr  input  32  RV64 instruction word.
REQ-007 SHALL have port alu_opcode  output  11  ALU operation code (package constants).
REQ-008 SHALL have ports alu_value1, alu_value2  output  64 each, signed operands.
REQ-009 SHALL have port alu_immediate  output  32  signed immediate.
REQ-010 SHALL have port alu_shamt  output  6  shift amount.
REQ-011 SHALL have port alu_result  input  64  ALU combinational result.
REQ-012 SHALL have ports retire_valid 1, retire_rd 5, retire_data 64, all output: one-cycle retire pulse.
REQ-013 SHALL have port illegal  output  1  one-cycle pulse on unsupported instruction.

Function
REQ-014 SHALL contain a 32x64 register file; x0 reads 0, writes to x0 discarded.
REQ-015 SHALL implement FSM IDLE -> EXEC -> WB -> IDLE; in_ready=1 only in IDLE.
REQ-016 Handshake: accept when in_valid && in_ready; in_instr sampled that edge only.
REQ-017 Supported: OP funct7 0000000: ADD, XOR, OR, AND, SLL, SRL; OP funct7 0100000: SUB; OP-IMM: ADDI, XORI, ORI, ANDI, SLLI, SRLI (imm[11:6]=0).
REQ-018 Anything else (incl. SRA/SRAI, SLT*, OP-32, nonzero x0-irrelevant) SHALL stay IDLE, pulse illegal next cycle, no write, no retire.
REQ-019 R-type non-shift: value1=rs1, value2=rs2, immediate=0, shamt=0.
REQ-020 I-type non-shift: value1=rs1, value2=sext(imm), immediate=sext(imm) (result correct even when imm=0).
REQ-021 Shifts: immediate=0, value2=0, shamt=imm[5:0] (SLLI/SRLI) or rs2[5:0] (SLL/SRL).
REQ-022 ALU outputs SHALL be held constant for all EXEC cycles; opcode=NOTHING and all operands 0 in IDLE and WB.
REQ-023 EXEC lasts exactly EXEC_CYCLES cycles (down-counter); alu_result captured on last EXEC edge.
REQ-024 WB: retire_valid=1 one cycle with rd and captured data; regfile written same edge; latency accept-to-retire = EXEC_CYCLES+1 cycles.
REQ-025 Operands read at EXEC entry; back-to-back dependent instruction SHALL see prior WB value (write precedes next accept).
REQ-026 retire_* SHALL be 0 whenever retire_valid=0.

Reset
REQ-027 reset SHALL force IDLE, clear counter, all registers to 0, all outputs 0 except in_ready=0 during reset, 1 first cycle after.
REQ-028 reset mid-EXEC/WB SHALL abort without regfile write or retire pulse.

Configuration
REQ-029 Macro ALU_ISSUE_MEXT_EN defined: OP funct7 0000001 MUL, DIV, REM decode to ALU MUL/DIV/REM.
REQ-030 With ALU_ISSUE_MEXT_EN, DIV/REM with rs2=0 SHALL bypass ALU (opcode NOTHING) and retire all-ones (DIV) or rs1 (REM) with same latency.
REQ-031 Without ALU_ISSUE_MEXT_EN, funct7 0000001 SHALL be illegal per REQ-018.

Structure
REQ-032 Package alu_pkg SHALL hold ALU opcode constants (NOTHING=0 .. ARTHRIGHT=12), RV opcode/funct3/funct7 constants, FSM state enum.
REQ-033 Register file SHALL be sub-module issue_regfile (2 read, 1 write, sync reset).

Verification
REQ-034 ADDI x1,x0,5 then ADD x2,x1,x1 -> retires x1=5, then x2=10, each EXEC_CYCLES+1 after accept.
REQ-035 ADDI x3,x0,0 with x3 preloaded 7 -> retire_data=0, alu_value2=0, alu_immediate=0.
REQ-036 SLLI x4,x1,63 with x1=1 -> alu_shamt=63, immediate=0, retire 0x8000_0000_0000_0000.
REQ-037 SRAI and ADD x0,x1,x1 -> SRAI pulses illegal, no retire; ADD x0 retires rd=0, x0 still reads 0.
REQ-038 ALU_ISSUE_MEXT_EN: DIV x5,x1,x0 with x1=9 -> retire all-ones; REM -> 9; undefined build -> illegal.
REQ-039 EXEC_CYCLES=3, reset asserted second EXEC cycle -> no retire, regfile unchanged, in_ready=1 after reset.
